// File: rtl/instr_encoder_loader_pkg.sv
// Shared types for the RV32I instruction encoder/loader: request kinds,
// opcode constants common with main_decoder, and loader FSM states.
package instr_enc_pkg;

  localparam int unsigned WORD_W = 32;
  localparam int unsigned REG_W  = 5;

  typedef enum logic [2:0] {
    KIND_LW  = 3'd0,
    KIND_SW  = 3'd1,
    KIND_R   = 3'd2,
    KIND_BEQ = 3'd3,
    KIND_I   = 3'd4,
    KIND_JAL = 3'd5,
    KIND_LUI = 3'd6,
    KIND_ILL = 3'd7
  } kind_e;

  localparam logic [6:0] OPC_LOAD   = 7'b0000011;
  localparam logic [6:0] OPC_STORE  = 7'b0100011;
  localparam logic [6:0] OPC_RTYPE  = 7'b0110011;
  localparam logic [6:0] OPC_BRANCH = 7'b1100011;
  localparam logic [6:0] OPC_OPIMM  = 7'b0010011;
  localparam logic [6:0] OPC_JAL    = 7'b1101111;
  localparam logic [6:0] OPC_LUI    = 7'b0110111;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_RUN  = 2'd1,
    ST_DONE = 2'd2
  } state_e;

  typedef struct packed {
    kind_e              kind;
    logic [REG_W-1:0]   rd;
    logic [REG_W-1:0]   rs1;
    logic [REG_W-1:0]   rs2;
    logic [2:0]         funct3;
    logic               funct7b5;
    logic [WORD_W-1:0]  imm;
  } enc_req_t;

endpackage

// File: rtl/instr_encoder_loader_if.sv
// Request handshake, instruction-memory write port and status of the loader.
interface instr_encoder_loader_if
  import instr_enc_pkg::*;
#(
  parameter int unsigned ADDR_W = 32,
  parameter int unsigned CNT_W  = 16
) ();

  logic              start;
  logic [ADDR_W-1:0] start_addr;
  logic              in_valid;
  logic              in_ready;
  kind_e             in_kind;
  logic [REG_W-1:0]  in_rd;
  logic [REG_W-1:0]  in_rs1;
  logic [REG_W-1:0]  in_rs2;
  logic [2:0]        in_funct3;
  logic              in_funct7b5;
  logic [WORD_W-1:0] in_imm;
  logic              in_last;
  logic              imem_we;
  logic [ADDR_W-1:0] imem_addr;
  logic [WORD_W-1:0] imem_wdata;
  logic              imem_ready;
  logic              busy;
  logic              done;
  logic [CNT_W-1:0]  wr_count;
  logic              err_illegal;

  modport slave (
    input  start, start_addr, in_valid, in_kind, in_rd, in_rs1, in_rs2,
           in_funct3, in_funct7b5, in_imm, in_last, imem_ready,
    output in_ready, imem_we, imem_addr, imem_wdata, busy, done,
           wr_count, err_illegal
  );

  modport master (
    output start, start_addr, in_valid, in_kind, in_rd, in_rs1, in_rs2,
           in_funct3, in_funct7b5, in_imm, in_last, imem_ready,
    input  in_ready, imem_we, imem_addr, imem_wdata, busy, done,
           wr_count, err_illegal
  );

endinterface

// File: rtl/instr_encoder_loader_word_pack.sv
// Combinational RV32I word assembly from a symbolic request; flags
// unencodable requests (kind 7, odd branch/jump offsets).
module instr_word_pack
  import instr_enc_pkg::*;
(
  input  enc_req_t           req_i,
  output logic [WORD_W-1:0]  word_c_o,
  output logic               illegal_c_o
);

  logic [6:0]  f7;
  logic [31:0] imm;

  assign f7  = {1'b0, req_i.funct7b5, 5'b00000};
  assign imm = req_i.imm;

  always_comb begin
    word_c_o    = '0;
    illegal_c_o = 1'b0;
    case (req_i.kind)
      KIND_LW:  word_c_o = {imm[11:0], req_i.rs1, 3'b010, req_i.rd, OPC_LOAD};
      KIND_SW:  word_c_o = {imm[11:5], req_i.rs2, req_i.rs1, 3'b010, imm[4:0], OPC_STORE};
      KIND_R:   word_c_o = {f7, req_i.rs2, req_i.rs1, req_i.funct3, req_i.rd, OPC_RTYPE};
      KIND_BEQ: begin
        word_c_o    = {imm[12], imm[10:5], req_i.rs2, req_i.rs1, 3'b000,
                       imm[4:1], imm[11], OPC_BRANCH};
        illegal_c_o = imm[0];
      end
      KIND_I: begin
        // Shifts carry funct7 in the upper immediate bits
        if (req_i.funct3 == 3'b001 || req_i.funct3 == 3'b101) begin
          word_c_o = {f7, imm[4:0], req_i.rs1, req_i.funct3, req_i.rd, OPC_OPIMM};
        end else begin
          word_c_o = {imm[11:0], req_i.rs1, req_i.funct3, req_i.rd, OPC_OPIMM};
        end
      end
      KIND_JAL: begin
        word_c_o    = {imm[20], imm[10:1], imm[11], imm[19:12], req_i.rd, OPC_JAL};
        illegal_c_o = imm[0];
      end
      KIND_LUI: word_c_o = {imm[31:12], req_i.rd, OPC_LUI};
      default:  illegal_c_o = 1'b1;
    endcase
  end

endmodule

// File: rtl/instr_encoder_loader.sv
// Program loader: accepts symbolic instruction requests, encodes them and
// writes the words to instruction memory at consecutive addresses.
module instr_encoder_loader
  import instr_enc_pkg::*;
#(
  parameter int unsigned ADDR_W = 32,
  parameter int unsigned CNT_W  = 16
) (
  input  logic                   clk,
  input  logic                   reset_n,
  instr_encoder_loader_if.slave  bus
);

  state_e            state_q, state_d;
  logic [ADDR_W-1:0] addr_q, addr_d;
  logic [WORD_W-1:0] wdata_q, wdata_d;
  logic              we_q, we_d;
  logic              wlast_q, wlast_d;
  logic              last_seen_q, last_seen_d;
  logic [CNT_W-1:0]  cnt_q, cnt_d;
  logic              err_q, err_d;

  enc_req_t          req;
  logic [WORD_W-1:0] word_c;
  logic              illegal_c;
  logic              in_ready_c;
  logic              accept_c;
  logic              write_done_c;

  always_comb begin
    req          = '0;
    req.kind     = bus.in_kind;
    req.rd       = bus.in_rd;
    req.rs1      = bus.in_rs1;
    req.rs2      = bus.in_rs2;
    req.funct3   = bus.in_funct3;
    req.funct7b5 = bus.in_funct7b5;
    req.imm      = bus.in_imm;
  end

  instr_word_pack u_pack (
    .req_i       (req),
    .word_c_o    (word_c),
    .illegal_c_o (illegal_c)
  );

  assign write_done_c = we_q && bus.imem_ready;
  assign in_ready_c   = (state_q == ST_RUN) && !last_seen_q && (!we_q || bus.imem_ready);
  assign accept_c     = bus.in_valid && in_ready_c;

  // Next-state: a draining write and a new accept may share one edge
  always_comb begin
    state_d     = state_q;
    addr_d      = addr_q;
    wdata_d     = wdata_q;
    we_d        = we_q;
    wlast_d     = wlast_q;
    last_seen_d = last_seen_q;
    cnt_d       = cnt_q;
    err_d       = err_q;
    case (state_q)
      ST_IDLE: begin
        if (bus.start) begin
          state_d     = ST_RUN;
          addr_d      = bus.start_addr & ~ADDR_W'(3);
          cnt_d       = '0;
          err_d       = 1'b0;
          last_seen_d = 1'b0;
          we_d        = 1'b0;
          wlast_d     = 1'b0;
        end
      end
      ST_RUN: begin
        if (write_done_c) begin
          we_d   = 1'b0;
          addr_d = addr_q + ADDR_W'(4);
          if (cnt_q != '1) cnt_d = cnt_q + CNT_W'(1);
          if (wlast_q) state_d = ST_DONE;
        end
        if (accept_c) begin
          last_seen_d = bus.in_last;
          if (illegal_c) begin
            err_d = 1'b1;
            if (bus.in_last) state_d = ST_DONE;
          end else begin
            we_d    = 1'b1;
            wdata_d = word_c;
            wlast_d = bus.in_last;
          end
        end
      end
      ST_DONE: state_d = ST_IDLE;
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      state_q     <= ST_IDLE;
      addr_q      <= '0;
      wdata_q     <= '0;
      we_q        <= 1'b0;
      wlast_q     <= 1'b0;
      last_seen_q <= 1'b0;
      cnt_q       <= '0;
      err_q       <= 1'b0;
    end else begin
      state_q     <= state_d;
      addr_q      <= addr_d;
      wdata_q     <= wdata_d;
      we_q        <= we_d;
      wlast_q     <= wlast_d;
      last_seen_q <= last_seen_d;
      cnt_q       <= cnt_d;
      err_q       <= err_d;
    end
  end

  assign bus.in_ready    = in_ready_c;
  assign bus.imem_we     = we_q;
  assign bus.imem_addr   = addr_q;
  assign bus.imem_wdata  = wdata_q;
  assign bus.busy        = (state_q != ST_IDLE);
  assign bus.done        = (state_q == ST_DONE);
  assign bus.wr_count    = cnt_q;
  assign bus.err_illegal = err_q;

endmodule

// File: tb/tb_instr_encoder_loader.sv
// Directed bench for instr_encoder_loader with hand-encoded expected words.
module tb_instr_encoder_loader;
  import instr_enc_pkg::*;

  logic clk;
  logic reset_n;
  int   n_checks;
  int   n_fails;

  instr_encoder_loader_if #(.ADDR_W(32), .CNT_W(16)) bus ();

  instr_encoder_loader #(.ADDR_W(32), .CNT_W(16)) dut (
    .clk     (clk),
    .reset_n (reset_n),
    .bus     (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog act=timeout exp=finish");
    $fatal(1, "watchdog expired");
  end

  task automatic chk(input string tag, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fails++;
      $display("FAIL %s act=0x%08h exp=0x%08h", tag, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input kind_e k, input logic [4:0] rd, input logic [4:0] rs1,
                       input logic [4:0] rs2, input logic [2:0] f3, input logic b5,
                       input logic [31:0] imm, input logic last);
    bus.in_valid    = 1'b1;
    bus.in_kind     = k;
    bus.in_rd       = rd;
    bus.in_rs1      = rs1;
    bus.in_rs2      = rs2;
    bus.in_funct3   = f3;
    bus.in_funct7b5 = b5;
    bus.in_imm      = imm;
    bus.in_last     = last;
  endtask

  task automatic do_start(input logic [31:0] addr);
    bus.start      = 1'b1;
    bus.start_addr = addr;
    tick();
    bus.start      = 1'b0;
  endtask

  initial begin
    n_checks        = 0;
    n_fails         = 0;
    reset_n         = 1'b0;
    bus.start       = 1'b0;
    bus.start_addr  = '0;
    bus.in_valid    = 1'b0;
    bus.in_kind     = KIND_LW;
    bus.in_rd       = '0;
    bus.in_rs1      = '0;
    bus.in_rs2      = '0;
    bus.in_funct3   = '0;
    bus.in_funct7b5 = 1'b0;
    bus.in_imm      = '0;
    bus.in_last     = 1'b0;
    bus.imem_ready  = 1'b1;
    tick();
    tick();
    chk("rst_we",    32'(bus.imem_we),     32'd0);
    chk("rst_addr",  bus.imem_addr,        32'd0);
    chk("rst_wdata", bus.imem_wdata,       32'd0);
    chk("rst_busy",  32'(bus.busy),        32'd0);
    chk("rst_done",  32'(bus.done),        32'd0);
    chk("rst_cnt",   32'(bus.wr_count),    32'd0);
    chk("rst_err",   32'(bus.err_illegal), 32'd0);
    chk("rst_rdy",   32'(bus.in_ready),    32'd0);
    reset_n = 1'b1;
    tick();

    // Valid while idle is not consumed
    drive(KIND_LW, 5'd1, 5'd1, 5'd1, 3'd0, 1'b0, 32'd0, 1'b0);
    #1;
    chk("idle_rdy", 32'(bus.in_ready), 32'd0);
    tick();
    bus.in_valid = 1'b0;
    chk("idle_busy", 32'(bus.busy), 32'd0);

    // sub x3, x1, x2 at misaligned start address
    do_start(32'h0000_0103);
    chk("t1_busy", 32'(bus.busy), 32'd1);
    chk("t1_rdy",  32'(bus.in_ready), 32'd1);
    drive(KIND_R, 5'd3, 5'd1, 5'd2, 3'b000, 1'b1, 32'd0, 1'b1);
    tick();
    bus.in_valid = 1'b0;
    chk("t1_we",    32'(bus.imem_we), 32'd1);
    chk("t1_addr",  bus.imem_addr,    32'h0000_0100);
    chk("t1_wdata", bus.imem_wdata,   32'h4020_81B3);
    tick();
    chk("t1_done",  32'(bus.done),     32'd1);
    chk("t1_cnt",   32'(bus.wr_count), 32'd1);
    chk("t1_we0",   32'(bus.imem_we),  32'd0);
    tick();
    chk("t1_done0", 32'(bus.done), 32'd0);
    chk("t1_idle",  32'(bus.busy), 32'd0);

    // Back-to-back lw / sw / lui at full throughput
    do_start(32'h0000_0200);
    drive(KIND_LW, 5'd5, 5'd2, 5'd0, 3'b000, 1'b0, 32'd8, 1'b0);
    tick();
    chk("t2_lw_w", bus.imem_wdata, 32'h0081_2283);
    chk("t2_lw_a", bus.imem_addr,  32'h0000_0200);
    drive(KIND_SW, 5'd0, 5'd2, 5'd5, 3'b000, 1'b0, 32'd12, 1'b0);
    #1;
    chk("t2_rdy", 32'(bus.in_ready), 32'd1);
    tick();
    chk("t2_sw_w", bus.imem_wdata, 32'h0051_2623);
    chk("t2_sw_a", bus.imem_addr,  32'h0000_0204);
    drive(KIND_LUI, 5'd6, 5'd0, 5'd0, 3'b000, 1'b0, 32'h1234_5000, 1'b1);
    tick();
    bus.in_valid = 1'b0;
    chk("t2_lui_w", bus.imem_wdata, 32'h1234_5337);
    chk("t2_lui_a", bus.imem_addr,  32'h0000_0208);
    chk("t2_we",    32'(bus.imem_we), 32'd1);
    tick();
    chk("t2_done", 32'(bus.done),     32'd1);
    chk("t2_cnt",  32'(bus.wr_count), 32'd3);
    tick();

    // beq stalled by memory for three cycles, lui waiting behind it
    do_start(32'h0000_0300);
    bus.imem_ready = 1'b0;
    drive(KIND_BEQ, 5'd0, 5'd1, 5'd2, 3'b000, 1'b0, 32'hFFFF_FFF8, 1'b0);
    tick();
    drive(KIND_LUI, 5'd7, 5'd0, 5'd0, 3'b000, 1'b0, 32'hABCD_E000, 1'b1);
    for (int i = 0; i < 3; i++) begin
      #1;
      chk("t3_we",    32'(bus.imem_we),  32'd1);
      chk("t3_wdata", bus.imem_wdata,    32'hFE20_8CE3);
      chk("t3_addr",  bus.imem_addr,     32'h0000_0300);
      chk("t3_rdy",   32'(bus.in_ready), 32'd0);
      tick();
    end
    bus.imem_ready = 1'b1;
    #1;
    chk("t3_rdy1", 32'(bus.in_ready), 32'd1);
    tick();
    bus.in_valid = 1'b0;
    chk("t3_lui_w", bus.imem_wdata, 32'hABCD_E3B7);
    chk("t3_lui_a", bus.imem_addr,  32'h0000_0304);
    tick();
    chk("t3_done", 32'(bus.done),     32'd1);
    chk("t3_cnt",  32'(bus.wr_count), 32'd2);
    tick();

    // jal, odd-offset beq, then kind 7 marked last
    do_start(32'h0000_0400);
    drive(KIND_JAL, 5'd1, 5'd0, 5'd0, 3'b000, 1'b0, 32'd2048, 1'b0);
    tick();
    chk("t4_jal_w", bus.imem_wdata, 32'h0010_00EF);
    chk("t4_jal_a", bus.imem_addr,  32'h0000_0400);
    drive(KIND_BEQ, 5'd0, 5'd1, 5'd2, 3'b000, 1'b0, 32'd5, 1'b0);
    tick();
    chk("t4_err",  32'(bus.err_illegal), 32'd1);
    chk("t4_we0",  32'(bus.imem_we),     32'd0);
    chk("t4_cnt1", 32'(bus.wr_count),    32'd1);
    drive(KIND_ILL, 5'd0, 5'd0, 5'd0, 3'b000, 1'b0, 32'd0, 1'b1);
    tick();
    bus.in_valid = 1'b0;
    chk("t4_done", 32'(bus.done),        32'd1);
    chk("t4_cnt",  32'(bus.wr_count),    32'd1);
    chk("t4_errd", 32'(bus.err_illegal), 32'd1);
    chk("t4_we",   32'(bus.imem_we),     32'd0);
    chk("t4_addr", bus.imem_addr,        32'h0000_0404);
    tick();
    chk("t4_idle", 32'(bus.busy), 32'd0);

    // Reset while a word is stalled discards it
    do_start(32'h0000_0500);
    chk("t5_err_clr", 32'(bus.err_illegal), 32'd0);
    bus.imem_ready = 1'b0;
    drive(KIND_LW, 5'd9, 5'd3, 5'd0, 3'b000, 1'b0, 32'd4, 1'b1);
    tick();
    bus.in_valid = 1'b0;
    tick();
    chk("t5_stall", 32'(bus.imem_we), 32'd1);
    reset_n = 1'b0;
    tick();
    reset_n = 1'b1;
    bus.imem_ready = 1'b1;
    chk("t5_we",   32'(bus.imem_we),  32'd0);
    chk("t5_addr", bus.imem_addr,     32'd0);
    chk("t5_wd",   bus.imem_wdata,    32'd0);
    chk("t5_busy", 32'(bus.busy),     32'd0);
    chk("t5_cnt",  32'(bus.wr_count), 32'd0);
    for (int i = 0; i < 3; i++) begin
      tick();
      chk("t5_nowr", 32'(bus.imem_we), 32'd0);
    end

    // Address wraps past the top of the space
    do_start(32'hFFFF_FFFC);
    drive(KIND_I, 5'd4, 5'd4, 5'd0, 3'b101, 1'b1, 32'd3, 1'b0);
    tick();
    chk("t6_a0", bus.imem_addr,  32'hFFFF_FFFC);
    chk("t6_w0", bus.imem_wdata, 32'h4032_5213);
    drive(KIND_I, 5'd8, 5'd1, 5'd0, 3'b000, 1'b0, 32'hFFFF_FFFF, 1'b1);
    tick();
    bus.in_valid = 1'b0;
    chk("t6_a1", bus.imem_addr,  32'h0000_0000);
    chk("t6_w1", bus.imem_wdata, 32'hFFF0_8413);
    tick();
    chk("t6_done", 32'(bus.done),     32'd1);
    chk("t6_cnt",  32'(bus.wr_count), 32'd2);
    tick();

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fails);
    $finish;
  end

endmodule
